// File: rtl/modsub_dual_pipe_pkg.sv
// Shared constants and types for the dual-mode modular subtract/add pipeline.
package modsub_dual_pipe_pkg;

  localparam int unsigned KYBER_Q     = 3329;
  localparam int unsigned DILITHIUM_Q = 8380417;

  typedef enum logic {
    MODE_KSUB = 1'b0,
    MODE_DADD = 1'b1
  } mode_e;

  // Stage-1 beat. Mode 0 packs {borrow_h, d_h[11:0], borrow_l, d_l[11:0]};
  // mode 1 packs {1'b0, s[24:0]}.
  typedef struct packed {
    logic        valid;
    mode_e       mode;
    logic [25:0] data;
  } s1_beat_t;

endpackage

// File: rtl/modsub_dual_pipe_align_delay.sv
// Enable-gated shift register with asynchronous active-low clear.
module modsub_dual_pipe_align_delay #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] hist_q [Depth];

  // Shift one slot per enabled cycle; idle cycles leave the history untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        hist_q[i] <= '0;
      end
    end else if (en_i) begin
      hist_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

  assign q_o = hist_q[Depth-1];

endmodule

// File: rtl/modsub_dual_pipe.sv
// Two-stage valid/ready pipeline: dual-lane 12-bit subtract mod KQ (mode 0)
// or single 24-bit add mod DQ (mode 1), with an operand-A alignment line.
module modsub_dual_pipe
  import modsub_dual_pipe_pkg::*;
#(
  parameter int unsigned KQ          = KYBER_Q,
  parameter int unsigned DQ          = DILITHIUM_Q,
  parameter int unsigned ALIGN_DEPTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        mode,
  input  logic        sel_align,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] sum
);

  localparam logic [11:0] KQ_12 = 12'(KQ);
  localparam logic [23:0] DQ_24 = 24'(DQ);
  localparam logic [24:0] DQ_25 = 25'(DQ);

  logic        en;
  logic        accept;
  logic [23:0] a_del;
  logic [23:0] a_eff;
  s1_beat_t    s1_d, s1_q;
  logic        out_valid_q;
  logic [23:0] sum_d, sum_q;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  // Raw a is captured on every accepted beat, whether or not it was used.
  modsub_dual_pipe_align_delay #(
    .Width(24),
    .Depth(ALIGN_DEPTH)
  ) u_align (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (accept),
    .d_i   (a),
    .q_o   (a_del)
  );

  assign a_eff = sel_align ? a_del : a;

  // Stage-1 next state: raw lane differences with borrow, or 25-bit sum.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = accept;
    s1_d.mode  = mode_e'(mode);
    if (s1_d.mode == MODE_KSUB) begin
      s1_d.data = {{1'b0, a_eff[23:12]} - {1'b0, b[23:12]},
                   {1'b0, a_eff[11:0]}  - {1'b0, b[11:0]}};
    end else begin
      s1_d.data = {1'b0, {1'b0, a_eff} + {1'b0, b}};
    end
  end

  // Stage-1 register; holds while the output is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
    end else if (en) begin
      s1_q <= s1_d;
    end
  end

  // Stage-2 correction: a single conditional add/subtract of the modulus.
  always_comb begin
    sum_d = '0;
    if (s1_q.mode == MODE_KSUB) begin
      sum_d[23:12] = s1_q.data[25] ? s1_q.data[24:13] + KQ_12 : s1_q.data[24:13];
      sum_d[11:0]  = s1_q.data[12] ? s1_q.data[11:0] + KQ_12  : s1_q.data[11:0];
    end else begin
      // Low 24 bits of (s - DQ) equal s[23:0] - DQ modulo 2^24.
      sum_d = (s1_q.data[24:0] >= DQ_25) ? s1_q.data[23:0] - DQ_24 : s1_q.data[23:0];
    end
  end

  // Output register; bubbles clear out_valid but leave sum untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
    end else if (en) begin
      out_valid_q <= s1_q.valid;
      if (s1_q.valid) begin
        sum_q <= sum_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_modsub_dual_pipe.sv
// Scoreboard bench for modsub_dual_pipe: stimulus pushes expected results,
// an independent monitor pops and compares on each output handshake.
module tb_modsub_dual_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        mode = 1'b0;
  logic        sel_align = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  modsub_dual_pipe #(
    .KQ         (3329),
    .DQ         (8380417),
    .ALIGN_DEPTH(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .sel_align(sel_align),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum)
  );

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%06h) expected %0d (0x%06h)", nm, act, act, expv, expv);
    end
  endtask

  // Monitor: sample just before the rising edge where the handshake lands.
  initial begin
    string       nm;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d expected no output", sum);
        end else begin
          nm = name_q.pop_front();
          e  = exp_q.pop_front();
          check(nm, sum, e);
        end
      end
    end
  end

  task automatic send(input logic m, input logic sel, input logic [23:0] av,
                      input logic [23:0] bv, input logic [23:0] expv, input string nm);
    bit acc = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    mode      = m;
    sel_align = sel;
    a         = av;
    b         = bv;
    for (int i = 0; i < 50; i++) begin
      #4;
      acc = in_ready;
      if (acc) begin
        exp_q.push_back(expv);
        name_q.push_back(nm);
      end
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout_%s: got in_ready 0 expected 1 within 50 cycles", nm);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string nm);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check(nm, 24'(exp_q.size()), 24'd0);
    exp_q.delete();
    name_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    exp_q.delete();
    name_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, checked while reset is held.
    #2;
    check("rst_out_valid", 24'(out_valid), 24'd0);
    check("rst_sum", sum, 24'd0);
    check("rst_in_ready", 24'(in_ready), 24'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1: mode-0 wrap on the high lane.
    send(1'b0, 1'b0, {12'd5, 12'd3328}, {12'd10, 12'd1}, {12'd3324, 12'd3327}, "m0_wrap");
    wait_drain("drain_t1");
    #4;
    check("t1_single_valid", 24'(out_valid), 24'd0);

    // 2: mode-1 boundaries, back to back.
    send(1'b1, 1'b0, 24'd8380416, 24'd1, 24'd0, "m1_wrap_zero");
    send(1'b1, 1'b0, 24'd8380416, 24'd8380416, 24'd8380415, "m1_max_sum");
    send(1'b1, 1'b0, 24'd100, 24'd200, 24'd300, "m1_small");
    wait_drain("drain_t2");

    // 3: backpressure for 3 cycles after the first result.
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          send(1'b1, 1'b0, 24'(k), 24'd0, 24'(k), $sformatf("bp_%0d", k));
        end
        idle(1);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
          @(negedge clk);
          #4;
          seen = out_valid;
        end
        check("bp_first_seen", 24'(seen), 24'd1);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          if (c != 0) @(negedge clk);
          #4;
          check($sformatf("bp_in_ready_%0d", c), 24'(in_ready), 24'd0);
          check($sformatf("bp_valid_%0d", c), 24'(out_valid), 24'd1);
          check($sformatf("bp_sum_hold_%0d", c), sum, 24'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_t3");

    // 4: alignment line with idle gaps; start from a cleared line.
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      send(1'b1, 1'b1, 24'(k), 24'd0, (k <= 6) ? 24'd0 : 24'(k - 6), $sformatf("align_%0d", k));
      if (k % 2 == 1) idle(2);
    end
    wait_drain("drain_t4");

    // 5: alternating modes.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        send(1'b0, 1'b0, {12'd0, 12'd0}, {12'd1, 12'd1}, {12'd3328, 12'd3328},
             $sformatf("mix_m0_%0d", k));
      end else begin
        send(1'b1, 1'b0, 24'd1, 24'd2, 24'd3, $sformatf("mix_m1_%0d", k));
      end
    end
    wait_drain("drain_t5");

    // 6: reset with two beats in flight, then alignment must read zero.
    send(1'b1, 1'b0, 24'd5, 24'd6, 24'd11, "pre_rst_0");
    send(1'b1, 1'b0, 24'd1, 24'd1, 24'd2, "pre_rst_1");
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 24'(out_valid), 24'd1);
    rst = 1'b0;
    exp_q.delete();
    name_q.delete();
    #1;
    check("mid_rst_out_valid", 24'(out_valid), 24'd0);
    check("mid_rst_sum", sum, 24'd0);
    check("mid_rst_in_ready", 24'(in_ready), 24'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 24'(in_ready), 24'd1);
    send(1'b1, 1'b1, 24'd7, 24'd42, 24'd42, "post_rst_align");
    wait_drain("drain_t6");
    #4;
    check("final_idle_valid", 24'(out_valid), 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
